// File: rtl/exc_commit_unit.sv
// ============================================================================
// Module   : exc_commit_unit
// Function : W-stage exception/interrupt commit with CP0 strobes and flush FSM
// Revision : 1.0
// ============================================================================
`default_nettype none

module exc_commit_unit #(
  parameter int          NUM_HW_INT   = 6,
  parameter int          NUM_SRC      = 8,
  parameter int          SYNC_STAGES  = 2,
  parameter int          FLUSH_CYCLES = 2,
  parameter logic [31:0] EXC_VECTOR   = 32'hBFC0_0380
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    valid_w,
  input  logic                    stall_w,
  input  logic [31:0]             pc_w,
  input  logic                    is_ds_w,
  input  logic [NUM_SRC-1:0]      exc_req,
  input  logic [5*NUM_SRC-1:0]    exc_codes,
  input  logic [NUM_SRC-1:0]      bv_sel,
  input  logic [31:0]             bad_vaddr_in,
  input  logic                    eret_w,
  input  logic [NUM_HW_INT-1:0]   hw_int,
  input  logic [1:0]              sw_int,
  input  logic                    status_ie,
  input  logic                    status_exl,
  input  logic [NUM_HW_INT+1:0]   status_im,
  input  logic [31:0]             epc_in,
  output logic [NUM_HW_INT+1:0]   cause_ip,
  output logic                    we_epc,
  output logic                    we_cause,
  output logic                    we_status,
  output logic                    we_badvaddr,
  output logic                    set_exl,
  output logic                    clr_exl,
  output logic [31:0]             epc_out,
  output logic [31:0]             badvaddr_out,
  output logic [4:0]              exc_code_out,
  output logic                    bd_out,
  output logic                    flush,
  output logic                    redirect_valid,
  output logic [31:0]             redirect_pc,
  output logic                    busy
);

  localparam int             C_CW          = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [C_CW-1:0] C_FLUSH_LAST = C_CW'(FLUSH_CYCLES - 1);

  localparam logic [1:0] C_ST_IDLE     = 2'd0;
  localparam logic [1:0] C_ST_FLUSH    = 2'd1;
  localparam logic [1:0] C_ST_REDIRECT = 2'd2;

  logic [SYNC_STAGES-1:0][NUM_HW_INT-1:0] r_sync;
  logic [1:0]      r_state;
  logic [C_CW-1:0] r_cnt;
  logic            r_we_epc, r_we_cause, r_we_status, r_we_badvaddr;
  logic            r_set_exl, r_clr_exl, r_bd;
  logic [31:0]     r_epc, r_badvaddr, r_redirect_pc;
  logic [4:0]      r_exc_code;

  logic [NUM_HW_INT+1:0] w_cause_ip;
  logic        w_int_pend, w_exc_any, w_eret_misal, w_commit, w_take_exc;
  logic        w_src_bv, w_bv_we, w_epc_we;
  logic [4:0]  w_src_code, w_code;
  logic [31:0] w_epc_val, w_bv_val;

  assign w_cause_ip   = {r_sync[SYNC_STAGES-1], sw_int};
  assign w_int_pend   = (|(w_cause_ip & status_im)) & status_ie & ~status_exl;
  assign w_exc_any    = |exc_req;
  assign w_eret_misal = eret_w & (epc_in[1:0] != 2'b00);
  assign w_commit     = (r_state == C_ST_IDLE) & valid_w & ~stall_w &
                        (w_int_pend | w_exc_any | eret_w);
  assign w_take_exc   = w_int_pend | w_exc_any | w_eret_misal;

  // Scan from the top so the lowest-indexed (highest priority) source wins.
  always_comb begin
    w_src_code = 5'd0;
    w_src_bv   = 1'b0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (exc_req[i]) begin
        w_src_code = exc_codes[5*i +: 5];
        w_src_bv   = bv_sel[i];
      end
    end
  end

  assign w_code    = w_int_pend ? 5'd0 : (w_exc_any ? w_src_code : 5'd4);
  assign w_bv_we   = ~w_int_pend & (w_exc_any ? w_src_bv : w_eret_misal);
  assign w_bv_val  = (~w_int_pend & ~w_exc_any) ? epc_in : bad_vaddr_in;
  // EPC/BD are preserved when a nested exception hits with EXL already set.
  assign w_epc_we  = w_int_pend | ~status_exl;
  assign w_epc_val = is_ds_w ? (pc_w - 32'd4) : pc_w;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync        <= '0;
      r_state       <= C_ST_IDLE;
      r_cnt         <= '0;
      r_we_epc      <= 1'b0;
      r_we_cause    <= 1'b0;
      r_we_status   <= 1'b0;
      r_we_badvaddr <= 1'b0;
      r_set_exl     <= 1'b0;
      r_clr_exl     <= 1'b0;
      r_bd          <= 1'b0;
      r_epc         <= '0;
      r_badvaddr    <= '0;
      r_redirect_pc <= '0;
      r_exc_code    <= '0;
    end else begin
      r_sync        <= {r_sync[SYNC_STAGES-2:0], hw_int};
      r_we_epc      <= 1'b0;
      r_we_cause    <= 1'b0;
      r_we_status   <= 1'b0;
      r_we_badvaddr <= 1'b0;
      r_set_exl     <= 1'b0;
      r_clr_exl     <= 1'b0;

      if (w_commit) begin
        r_we_status <= 1'b1;
        if (w_take_exc) begin
          r_we_epc      <= w_epc_we;
          r_we_cause    <= 1'b1;
          r_we_badvaddr <= w_bv_we;
          r_set_exl     <= 1'b1;
          r_exc_code    <= w_code;
          r_redirect_pc <= EXC_VECTOR;
          if (w_epc_we) begin
            r_epc <= w_epc_val;
            r_bd  <= is_ds_w;
          end
          if (w_bv_we) begin
            r_badvaddr <= w_bv_val;
          end
        end else begin
          r_clr_exl     <= 1'b1;
          r_redirect_pc <= epc_in;
        end
      end

      case (r_state)
        C_ST_IDLE: begin
          r_cnt <= '0;
          if (w_commit) begin
            r_state <= C_ST_FLUSH;
          end
        end
        C_ST_FLUSH: begin
          if (r_cnt == C_FLUSH_LAST) begin
            r_cnt   <= '0;
            r_state <= C_ST_REDIRECT;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        C_ST_REDIRECT: r_state <= C_ST_IDLE;
        default:       r_state <= C_ST_IDLE;
      endcase
    end
  end

  assign cause_ip       = w_cause_ip;
  assign we_epc         = r_we_epc;
  assign we_cause       = r_we_cause;
  assign we_status      = r_we_status;
  assign we_badvaddr    = r_we_badvaddr;
  assign set_exl        = r_set_exl;
  assign clr_exl        = r_clr_exl;
  assign epc_out        = r_epc;
  assign badvaddr_out   = r_badvaddr;
  assign exc_code_out   = r_exc_code;
  assign bd_out         = r_bd;
  assign redirect_pc    = r_redirect_pc;
  assign flush          = (r_state == C_ST_FLUSH);
  assign redirect_valid = (r_state == C_ST_REDIRECT);
  assign busy           = (r_state != C_ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_exc_commit_unit.sv
// ============================================================================
// Module   : tb_exc_commit_unit
// Function : Scoreboard bench for exc_commit_unit
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_exc_commit_unit;

  localparam int          NHW = 6;
  localparam int          NSRC = 8;
  localparam int          FC = 2;
  localparam logic [31:0] VEC = 32'hBFC0_0380;

  logic clk = 1'b0;
  logic rst;
  logic valid_w, stall_w, is_ds_w, eret_w, status_ie, status_exl;
  logic [31:0] pc_w, bad_vaddr_in, epc_in;
  logic [NSRC-1:0] exc_req, bv_sel;
  logic [5*NSRC-1:0] exc_codes;
  logic [NHW-1:0] hw_int;
  logic [1:0] sw_int;
  logic [NHW+1:0] status_im, cause_ip;
  logic we_epc, we_cause, we_status, we_badvaddr, set_exl, clr_exl, bd_out;
  logic flush, redirect_valid, busy;
  logic [31:0] epc_out, badvaddr_out, redirect_pc;
  logic [4:0] exc_code_out;

  typedef struct {
    logic [4:0]  code;
    logic [31:0] epc;
    logic        bd;
    logic        w_epc;
    logic        w_cause;
    logic        w_bv;
    logic [31:0] bv;
    logic        setx;
    logic        clrx;
    logic [31:0] rpc;
  } exp_t;

  exp_t sbq[$];
  int checks = 0;
  int errors = 0;

  exc_commit_unit #(
    .NUM_HW_INT(NHW), .NUM_SRC(NSRC), .SYNC_STAGES(2),
    .FLUSH_CYCLES(FC), .EXC_VECTOR(VEC)
  ) dut (
    .clk(clk), .rst(rst), .valid_w(valid_w), .stall_w(stall_w), .pc_w(pc_w),
    .is_ds_w(is_ds_w), .exc_req(exc_req), .exc_codes(exc_codes), .bv_sel(bv_sel),
    .bad_vaddr_in(bad_vaddr_in), .eret_w(eret_w), .hw_int(hw_int), .sw_int(sw_int),
    .status_ie(status_ie), .status_exl(status_exl), .status_im(status_im),
    .epc_in(epc_in), .cause_ip(cause_ip), .we_epc(we_epc), .we_cause(we_cause),
    .we_status(we_status), .we_badvaddr(we_badvaddr), .set_exl(set_exl),
    .clr_exl(clr_exl), .epc_out(epc_out), .badvaddr_out(badvaddr_out),
    .exc_code_out(exc_code_out), .bd_out(bd_out), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic cyc;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_idle;
    valid_w = 1'b0; stall_w = 1'b0; exc_req = '0; eret_w = 1'b0;
    bv_sel = '0; is_ds_w = 1'b0;
  endtask

  task automatic wait_strobe(output int n);
    n = 0;
    while (!(we_cause | we_status) && n < 16) begin
      cyc();
      n++;
    end
  endtask

  task automatic wait_redirect(output int n);
    n = 0;
    while (!redirect_valid && n < 16) begin
      cyc();
      n++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b0; set_idle(); pc_w = '0; bad_vaddr_in = '0; epc_in = '0;
    exc_codes = '0; hw_int = 6'h3F; sw_int = 2'b10; status_ie = 1'b0;
    status_exl = 1'b0; status_im = '0;
    cyc(); cyc();
    checks++; if (cause_ip !== 8'b0000_0010) begin errors++; $display("FAIL rst_cause_ip got %h exp 02", cause_ip); end
    checks++; if ({busy, flush, redirect_valid, we_epc, we_cause, we_status, we_badvaddr} !== 7'b0) begin
      errors++; $display("FAIL rst_ctrl got %b exp 0", {busy, flush, redirect_valid, we_epc, we_cause, we_status, we_badvaddr}); end
    checks++; if ({epc_out, exc_code_out, redirect_pc} !== '0) begin errors++; $display("FAIL rst_data got %h exp 0", {epc_out, exc_code_out, redirect_pc}); end
    hw_int = '0; sw_int = 2'b00; rst = 1'b1;
    cyc(); cyc(); cyc();
    // Start a sequence, then reset while it is flushing.
    exc_req = 8'h01; exc_codes[4:0] = 5'h0C; valid_w = 1'b1; pc_w = 32'h8000_0100;
    cyc(); set_idle();
    checks++; if (flush !== 1'b1) begin errors++; $display("FAIL pre_rst_flush got %b exp 1", flush); end
    rst = 1'b0; #1;
    checks++; if ({flush, busy, we_epc, we_cause, we_status, set_exl} !== 6'b0) begin
      errors++; $display("FAIL midrst got %b exp 0", {flush, busy, we_epc, we_cause, we_status, set_exl}); end
    @(negedge clk); rst = 1'b1;
    begin
      int seen = 0;
      for (int k = 0; k < 6; k++) begin cyc(); if (redirect_valid | busy) seen++; end
      checks++; if (seen !== 0) begin errors++; $display("FAIL post_rst_idle got %0d exp 0", seen); end
    end
  endtask

  task automatic test_exception;
    int n; exp_t e;
    exc_req = 8'b0000_0110; exc_codes[9:5] = 5'h0C; exc_codes[14:10] = 5'h05;
    pc_w = 32'h8000_1000; is_ds_w = 1'b1; status_exl = 1'b0; valid_w = 1'b1;
    sbq.push_back('{5'h0C, 32'h8000_0FFC, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, VEC});
    cyc(); set_idle();
    wait_strobe(n);
    checks++; if (n !== 0) begin errors++; $display("FAIL exc_latency got %0d exp 0", n); end
    e = sbq.pop_front();
    checks++; if (exc_code_out !== e.code) begin errors++; $display("FAIL exc_code got %h exp %h", exc_code_out, e.code); end
    checks++; if (epc_out !== e.epc || bd_out !== e.bd) begin errors++; $display("FAIL exc_epc got %h/%b exp %h/%b", epc_out, bd_out, e.epc, e.bd); end
    checks++; if ({we_epc, we_cause, we_badvaddr, set_exl, clr_exl} !== {e.w_epc, e.w_cause, e.w_bv, e.setx, e.clrx}) begin
      errors++; $display("FAIL exc_strobes got %b exp %b", {we_epc, we_cause, we_badvaddr, set_exl, clr_exl}, {e.w_epc, e.w_cause, e.w_bv, e.setx, e.clrx}); end
    checks++; if ({flush, busy} !== 2'b11) begin errors++; $display("FAIL exc_flush got %b exp 11", {flush, busy}); end
    wait_redirect(n);
    checks++; if (n !== FC || redirect_pc !== e.rpc) begin errors++; $display("FAIL exc_redirect got %0d/%h exp %0d/%h", n, redirect_pc, FC, e.rpc); end
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL exc_flush_end got %b exp 0", flush); end
    cyc();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL exc_busy_end got %b exp 0", busy); end
  endtask

  task automatic test_interrupt;
    int n; exp_t e;
    status_im = 8'h10; status_ie = 1'b1; status_exl = 1'b0; hw_int = 6'b000100;
    cyc();
    checks++; if (cause_ip[4] !== 1'b0) begin errors++; $display("FAIL int_sync1 got %b exp 0", cause_ip[4]); end
    cyc();
    checks++; if (cause_ip[4] !== 1'b1) begin errors++; $display("FAIL int_sync2 got %b exp 1", cause_ip[4]); end
    exc_req = 8'h01; exc_codes[4:0] = 5'h0A; bv_sel = 8'h01; eret_w = 1'b1;
    epc_in = 32'h8000_2000; pc_w = 32'h8000_3000; valid_w = 1'b1;
    sbq.push_back('{5'h00, 32'h8000_3000, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, VEC});
    cyc(); set_idle(); status_ie = 1'b0; hw_int = '0;
    wait_strobe(n);
    e = sbq.pop_front();
    checks++; if (n !== 0 || exc_code_out !== e.code) begin errors++; $display("FAIL int_code got %h@%0d exp %h@0", exc_code_out, n, e.code); end
    checks++; if (epc_out !== e.epc || bd_out !== e.bd) begin errors++; $display("FAIL int_epc got %h/%b exp %h/%b", epc_out, bd_out, e.epc, e.bd); end
    checks++; if ({we_epc, we_badvaddr, clr_exl, set_exl} !== {e.w_epc, e.w_bv, e.clrx, e.setx}) begin
      errors++; $display("FAIL int_strobes got %b exp %b", {we_epc, we_badvaddr, clr_exl, set_exl}, {e.w_epc, e.w_bv, e.clrx, e.setx}); end
    wait_redirect(n);
    checks++; if (redirect_pc !== e.rpc) begin errors++; $display("FAIL int_redirect got %h exp %h", redirect_pc, e.rpc); end
    cyc(); cyc(); cyc();
  endtask

  task automatic test_eret;
    int n; exp_t e;
    status_exl = 1'b1; bad_vaddr_in = 32'h1111_1111;
    eret_w = 1'b1; epc_in = 32'h8000_2002; pc_w = 32'h8000_0200; valid_w = 1'b1;
    sbq.push_back('{5'h04, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h8000_2002, 1'b1, 1'b0, VEC});
    cyc(); set_idle();
    wait_strobe(n);
    e = sbq.pop_front();
    checks++; if (exc_code_out !== e.code || badvaddr_out !== e.bv) begin errors++; $display("FAIL adel got %h/%h exp %h/%h", exc_code_out, badvaddr_out, e.code, e.bv); end
    checks++; if ({we_epc, we_cause, we_badvaddr, set_exl} !== {e.w_epc, e.w_cause, e.w_bv, e.setx}) begin
      errors++; $display("FAIL adel_strobes got %b exp %b", {we_epc, we_cause, we_badvaddr, set_exl}, {e.w_epc, e.w_cause, e.w_bv, e.setx}); end
    wait_redirect(n);
    checks++; if (redirect_pc !== e.rpc) begin errors++; $display("FAIL adel_redirect got %h exp %h", redirect_pc, e.rpc); end
    cyc();
    eret_w = 1'b1; epc_in = 32'h8000_2000; valid_w = 1'b1;
    sbq.push_back('{5'h04, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h8000_2000});
    cyc(); set_idle();
    wait_strobe(n);
    e = sbq.pop_front();
    checks++; if ({we_epc, we_cause, we_badvaddr, set_exl, clr_exl, we_status} !== {e.w_epc, e.w_cause, e.w_bv, e.setx, e.clrx, 1'b1}) begin
      errors++; $display("FAIL eret_strobes got %b exp %b", {we_epc, we_cause, we_badvaddr, set_exl, clr_exl, we_status}, {e.w_epc, e.w_cause, e.w_bv, e.setx, e.clrx, 1'b1}); end
    wait_redirect(n);
    checks++; if (n !== FC || redirect_pc !== e.rpc) begin errors++; $display("FAIL eret_redirect got %0d/%h exp %0d/%h", n, redirect_pc, FC, e.rpc); end
    cyc();
    status_exl = 1'b0;
  endtask

  task automatic test_stall;
    int n; int bad; exp_t e;
    exc_req = 8'h08; exc_codes = {NSRC{5'h1F}}; exc_codes[19:15] = 5'h0A; bv_sel = 8'h08;
    bad_vaddr_in = 32'hDEAD_BEEF; pc_w = 32'h8000_4000; valid_w = 1'b1; stall_w = 1'b1;
    sbq.push_back('{5'h0A, 32'h8000_4000, 1'b0, 1'b1, 1'b1, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, VEC});
    bad = 0;
    for (int k = 0; k < 3; k++) begin cyc(); if (we_cause | we_status | busy) bad++; end
    checks++; if (bad !== 0) begin errors++; $display("FAIL stall_quiet got %0d exp 0", bad); end
    stall_w = 1'b0;
    cyc(); set_idle();
    wait_strobe(n);
    e = sbq.pop_front();
    checks++; if (n !== 0 || exc_code_out !== e.code) begin errors++; $display("FAIL stall_code got %h@%0d exp %h@0", exc_code_out, n, e.code); end
    checks++; if (badvaddr_out !== e.bv || we_badvaddr !== e.w_bv || epc_out !== e.epc) begin
      errors++; $display("FAIL stall_bv got %h/%b/%h exp %h/%b/%h", badvaddr_out, we_badvaddr, epc_out, e.bv, e.w_bv, e.epc); end
    wait_redirect(n);
    cyc();
  endtask

  task automatic test_back_to_back;
    int n; int pulses; exp_t e;
    exc_codes = '0; exc_req = 8'h20; exc_codes[29:25] = 5'h0D; pc_w = 32'h8000_5000; valid_w = 1'b1;
    sbq.push_back('{5'h0D, 32'h8000_5000, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, VEC});
    cyc();
    exc_req = 8'h01; exc_codes[4:0] = 5'h07;
    pulses = (we_cause ? 1 : 0);
    e = sbq.pop_front();
    checks++; if (exc_code_out !== e.code || epc_out !== e.epc) begin errors++; $display("FAIL b2b_first got %h/%h exp %h/%h", exc_code_out, epc_out, e.code, e.epc); end
    n = 0;
    while (!redirect_valid && n < 16) begin
      cyc(); n++;
      if (we_cause) pulses++;
    end
    valid_w = 1'b0;
    checks++; if (pulses !== 1) begin errors++; $display("FAIL b2b_pulses got %0d exp 1", pulses); end
    checks++; if (exc_code_out !== e.code) begin errors++; $display("FAIL b2b_hold got %h exp %h", exc_code_out, e.code); end
    cyc();
    checks++; if ({busy, we_cause} !== 2'b00) begin errors++; $display("FAIL b2b_end got %b exp 00", {busy, we_cause}); end
    set_idle();
  endtask

  initial begin
    test_reset();
    test_exception();
    test_interrupt();
    test_eret();
    test_stall();
    test_back_to_back();
    checks++; if (sbq.size() !== 0) begin errors++; $display("FAIL sb_leftover got %0d exp 0", sbq.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/exc_commit_unit.md
# exc_commit_unit

Parametrised exception/interrupt commit unit at the writeback (W) stage. It collects synchronous exception flags for the W instruction, synchronises external interrupt lines, arbitrates by fixed priority and produces one-cycle CP0 write strobes. It then runs a flush/redirect sequence towards the fetch stage. It succeeds the combinational exception decoder with configurable source/interrupt counts, registered outputs, interrupt synchronisers and a multi-cycle flush FSM.

## Interface
Parameters:
- NUM_HW_INT, 6, number of external hardware interrupt lines
- NUM_SRC, 8, number of synchronous exception sources; bit 0 highest priority
- SYNC_STAGES, 2, flip-flop depth of each hw_int synchroniser (>=2)
- FLUSH_CYCLES, 2, cycles `flush` is held before redirect (>=1)
- EXC_VECTOR, 32'hBFC0_0380, general exception entry PC

Ports:
- clk  in  1  clock; all state on rising edge
- rst  in  1  asynchronous, active-low reset (0 = reset)
- valid_w  in  1  W-stage instruction valid
- stall_w  in  1  W stage stalled; no commit while high
- pc_w  in  32  PC of W instruction
- is_ds_w  in  1  W instruction is in a branch delay slot
- exc_req  in  NUM_SRC  exception flags of W instruction
- exc_codes  in  5*NUM_SRC  ExcCode per source, source i at [5i+4:5i]
- bv_sel  in  NUM_SRC  source i loads BadVAddr when taken
- bad_vaddr_in  in  32  faulting address for BadVAddr-loading sources
- eret_w  in  1  W instruction is ERET
- hw_int  in  NUM_HW_INT  asynchronous external interrupts
- sw_int  in  2  Cause software interrupt bits
- status_ie, status_exl  in  1 each  Status.IE, Status.EXL
- status_im  in  NUM_HW_INT+2  interrupt mask
- epc_in  in  32  current EPC (ERET target)
- cause_ip  out  NUM_HW_INT+2  {synced hw_int, sw_int}
- we_epc, we_cause, we_status, we_badvaddr  out  1 each  one-cycle CP0 write strobes
- set_exl, clr_exl  out  1 each  Status.EXL update (valid with we_status)
- epc_out, badvaddr_out  out  32 each
- exc_code_out  out  5;  bd_out  out  1
- flush  out  1  kill all pipeline stages
- redirect_valid  out  1;  redirect_pc  out  32
- busy  out  1  FSM not IDLE

## Operation
- Sync: each hw_int bit through SYNC_STAGES flops; cause_ip = {sync, sw_int} (sw_int combinational).
- int_pend = |(cause_ip & status_im) & status_ie & !status_exl.
- Commit condition (IDLE only): valid_w & !stall_w. Priority at commit:
  1. int_pend -> ExcCode 0.
  2. any exc_req -> lowest set index i, ExcCode from exc_codes[i]; BadVAddr written iff bv_sel[i].
  3. eret_w with epc_in[1:0]!=0 -> AdEL (ExcCode 4), badvaddr_out=epc_in, BadVAddr written.
  4. eret_w, aligned -> ERET: clr_exl, redirect to epc_in, no EPC/Cause write.
- Exceptions while status_exl=1 (cases 2,3): taken, but EPC/BD not updated (we_epc=0).
- Exception/interrupt: epc_out = is_ds_w ? pc_w-4 : pc_w (mod 2^32); bd_out=is_ds_w; set_exl=1; redirect_pc=EXC_VECTOR.
- FSM: IDLE -> FLUSH (commit) -> FLUSH counts FLUSH_CYCLES -> REDIRECT (1 cycle) -> IDLE. Commits ignored unless IDLE.

## Timing
- Commit sampled at edge T; at T+1: we_* strobes (1 cycle), flush=1, busy=1, epc_out/badvaddr_out/exc_code_out/bd_out valid and held until next commit.
- flush high cycles T+1..T+FLUSH_CYCLES; redirect_valid=1 with redirect_pc at T+FLUSH_CYCLES+1 only; busy drops at T+FLUSH_CYCLES+2.
- hw_int edge visible in cause_ip after SYNC_STAGES edges.
- Reset (rst=0, any time incl. mid-sequence): state IDLE, all outputs and sync flops 0 immediately; cause_ip = {0, sw_int}.
- stall_w=1 with pending event: nothing taken; taken on first non-stalled valid cycle.
- Simultaneous interrupt + exception + ERET: interrupt wins; others discarded (instruction flushed, re-executed).

## Test plan
- Reset: rst=0 mid-FLUSH -> flush, busy, we_* = 0 same cycle; after release IDLE, no redirect.
- exc_req=8'b0000_0110, exc_codes[1]=5'h0C, pc_w=32'h8000_1000, is_ds_w=1 -> T+1: exc_code_out=0x0C, epc_out=32'h8000_0FFC, bd_out=1, we_epc=1; redirect_pc=32'hBFC0_0380 at T+3.
- hw_int[2] rises, status_im[4]=1, ie=1, exl=0, exc_req[0]=1 -> after 2 cycles interrupt taken, exc_code_out=0, cause_ip[4]=1.
- eret_w=1, epc_in=32'h8000_2002 -> exc_code_out=4, badvaddr_out=32'h8000_2002, we_badvaddr=1; aligned epc_in=32'h8000_2000 -> clr_exl=1, we_epc=0, redirect_pc=32'h8000_2000.
- stall_w=1 for 3 cycles with exc_req set -> no strobes; commit on first cycle stall_w=0.
- Second commit request while busy -> ignored; exactly one we_* pulse per sequence.
